// File: rtl/tow_pkg.sv
// tow_pkg: shared FSM state and winner encodings for the tug-of-war referee.
package tow_pkg;
    typedef enum logic [1:0] {S_FIELD_RST, S_PLAY, S_HOLD, S_MATCH_OVER} state_t;
    typedef enum logic [1:0] {W_NONE = 2'd0, W_LEFT = 2'd1, W_RIGHT = 2'd2} winner_t;
endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: two-flop synchroniser plus rising-edge detector for one raw key.
module key_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic ev
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], key_raw};
    end
    assign ev = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/tug_of_war_referee.sv
// tug_of_war_referee: key conditioning, point detection, scoring and match control for the light field.
module tug_of_war_referee
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS   = 9,
    parameter int SCORE_W      = 3,
    parameter int MATCH_POINTS = 7,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_l,
    input  logic                  key_r,
    input  logic                  new_match,
    input  logic [NUM_LIGHTS-1:0] light_vec,
    output logic                  press_l,
    output logic                  press_r,
    output logic                  field_reset,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic [1:0]            winner,
    output logic                  match_over
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic ev_l, ev_r, lone_l, lone_r;
    state_t state_q, state_d;
    winner_t winner_q, winner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d, sl_inc, sr_inc;
    logic press_l_q, press_l_d, press_r_q, press_r_d;
    logic field_reset_q, field_reset_d, match_over_q, match_over_d;

    key_edge_sync u_sync_l (.clk(clk), .reset(reset), .key_raw(key_l), .ev(ev_l));
    key_edge_sync u_sync_r (.clk(clk), .reset(reset), .key_raw(key_r), .ev(ev_r));

    // Simultaneous events cancel each other.
    assign lone_l = ev_l & ~ev_r;
    assign lone_r = ev_r & ~ev_l;
    assign sl_inc = score_l_q + SCORE_W'(1);
    assign sr_inc = score_r_q + SCORE_W'(1);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;
        press_l_d = 1'b0;
        press_r_d = 1'b0;
        case (state_q)
            S_FIELD_RST: state_d = S_PLAY;
            S_PLAY: begin
                if (lone_l && light_vec[NUM_LIGHTS-1]) begin
                    score_l_d = sl_inc;
                    if (sl_inc == SCORE_W'(MATCH_POINTS)) begin
                        winner_d = W_LEFT;
                        state_d  = S_MATCH_OVER;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLD_CYCLES - 1);
                    end
                end else if (lone_r && light_vec[0]) begin
                    score_r_d = sr_inc;
                    if (sr_inc == SCORE_W'(MATCH_POINTS)) begin
                        winner_d = W_RIGHT;
                        state_d  = S_MATCH_OVER;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLD_CYCLES - 1);
                    end
                end else begin
                    press_l_d = lone_l;
                    press_r_d = lone_r;
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_FIELD_RST;
                else              hold_d  = hold_q - HW'(1);
            end
            S_MATCH_OVER: begin
                if (new_match) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = W_NONE;
                    state_d   = S_FIELD_RST;
                end
            end
            default: state_d = S_FIELD_RST;
        endcase
        field_reset_d = (state_d == S_FIELD_RST);
        match_over_d  = (state_d == S_MATCH_OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FIELD_RST;
            hold_q        <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            winner_q      <= W_NONE;
            press_l_q     <= 1'b0;
            press_r_q     <= 1'b0;
            field_reset_q <= 1'b1;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            winner_q      <= winner_d;
            press_l_q     <= press_l_d;
            press_r_q     <= press_r_d;
            field_reset_q <= field_reset_d;
            match_over_q  <= match_over_d;
        end
    end

    assign press_l     = press_l_q;
    assign press_r     = press_r_q;
    assign field_reset = field_reset_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign winner      = winner_q;
    assign match_over  = match_over_q;
endmodule
